// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and default CDC depth.
`timescale 1ns/1ps
package fifo_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int GRAY_MAX_W = 32;

  // Any width up to GRAY_MAX_W is handled: callers zero-extend the argument and
  // truncate the result, which is exact because leading zeros convert to zeros.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_ff.sv
// Multi-flop synchroniser for one Gray-coded pointer crossing into the clk domain.
`timescale 1ns/1ps
module fifo_sync_ff #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/async_fifo.sv
// Dual-clock FIFO with Gray-code pointer crossing, registered flags/counts and
// overflow/underflow pulses. Memory is a simple dual-port array with registered read.
`timescale 1ns/1ps
module async_fifo
  import fifo_pkg::*;
#(
  parameter int WD          = 32,
  parameter int AW          = 4,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int AFULL_TH    = 2**AW - 2,
  parameter int AEMPTY_TH   = 2
) (
  input  logic          rst,
  input  logic          clk_we,
  input  logic          clk_re,
  input  logic          we,
  input  logic [WD-1:0] wdata,
  output logic          full,
  output logic          afull,
  output logic [AW:0]   wr_count,
  output logic          overflow,
  input  logic          re,
  output logic [WD-1:0] rdata,
  output logic          rvalid,
  output logic          empty,
  output logic          aempty,
  output logic [AW:0]   rd_count,
  output logic          underflow
);

  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [PW-1:0] AFULL_TH_P  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_TH_P = PW'(AEMPTY_TH);

  // Handshake: we/re are requests sampled on their own clock edge. A request is
  // accepted only when full/empty (as registered before that edge) is low; a
  // rejected request changes no state and raises overflow/underflow for one cycle.

  logic [WD-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wbin, wgray, wbin_next, wgray_next;
  logic [PW-1:0] rgray_sync, rbin_sync, wr_level, full_ref;
  logic          wr_accept;

  assign wr_accept  = we && !full;
  assign wbin_next  = wbin + PW'(wr_accept);
  assign wgray_next = PW'(bin2gray(GRAY_MAX_W'(wbin_next)));
  assign rbin_sync  = PW'(gray2bin(GRAY_MAX_W'(rgray_sync)));
  assign wr_level   = wbin_next - rbin_sync;
  // Full when the write pointer is one whole lap ahead: top two Gray bits inverted.
  assign full_ref   = {~rgray_sync[AW:AW-1], rgray_sync[AW-2:0]};

  always_ff @(posedge clk_we or negedge rst) begin
    if (!rst) begin
      wbin     <= '0;
      wgray    <= '0;
      full     <= 1'b0;
      afull    <= 1'b0;
      wr_count <= '0;
      overflow <= 1'b0;
    end else begin
      wbin     <= wbin_next;
      wgray    <= wgray_next;
      full     <= (wgray_next == full_ref);
      afull    <= (wr_level >= AFULL_TH_P);
      wr_count <= wr_level;
      overflow <= we && full;
    end
  end

  always_ff @(posedge clk_we) begin
    if (wr_accept) begin
      mem[wbin[AW-1:0]] <= wdata;
    end
  end

  // ---------------- read domain ----------------
  logic [PW-1:0] rbin, rgray, rbin_next, rgray_next;
  logic [PW-1:0] wgray_sync, wbin_sync, rd_level;
  logic          rd_accept;

  assign rd_accept  = re && !empty;
  assign rbin_next  = rbin + PW'(rd_accept);
  assign rgray_next = PW'(bin2gray(GRAY_MAX_W'(rbin_next)));
  assign wbin_sync  = PW'(gray2bin(GRAY_MAX_W'(wgray_sync)));
  assign rd_level   = wbin_sync - rbin_next;

  always_ff @(posedge clk_re or negedge rst) begin
    if (!rst) begin
      rbin      <= '0;
      rgray     <= '0;
      empty     <= 1'b1;
      aempty    <= 1'b1;
      rd_count  <= '0;
      underflow <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
    end else begin
      rbin      <= rbin_next;
      rgray     <= rgray_next;
      empty     <= (rgray_next == wgray_sync);
      aempty    <= (rd_level <= AEMPTY_TH_P);
      rd_count  <= rd_level;
      underflow <= re && empty;
      rvalid    <= rd_accept;
      if (rd_accept) begin
        rdata <= mem[rbin[AW-1:0]];
      end
    end
  end

  // ---------------- pointer crossings (Gray only) ----------------
  fifo_sync_ff #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk (clk_re),
    .rst (rst),
    .d   (wgray),
    .q   (wgray_sync)
  );

  fifo_sync_ff #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk (clk_we),
    .rst (rst),
    .d   (rgray),
    .q   (rgray_sync)
  );

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: table-driven fill/drain plus hand-written
// latency, reset and randomised-stall streaming sequences in two clock ratios.
`timescale 1ns/1ps
module tb_async_fifo;

  localparam int WD = 32;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic    clk_we = 1'b0;
  logic    clk_re = 1'b0;
  logic    rst    = 1'b1;
  realtime we_half = 5.0;
  realtime re_half = 13.5;

  always begin #(we_half) clk_we = ~clk_we; end
  always begin #(re_half) clk_re = ~clk_re; end

  logic          we = 1'b0, re = 1'b0;
  logic [WD-1:0] wdata = '0;
  logic          full, afull, overflow, rvalid, empty, aempty, underflow;
  logic [AW:0]   wr_count, rd_count;
  logic [WD-1:0] rdata;

  async_fifo #(.WD(WD), .AW(AW)) dut (
    .rst       (rst),
    .clk_we    (clk_we),
    .clk_re    (clk_re),
    .we        (we),
    .wdata     (wdata),
    .full      (full),
    .afull     (afull),
    .wr_count  (wr_count),
    .overflow  (overflow),
    .re        (re),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .empty     (empty),
    .aempty    (aempty),
    .rd_count  (rd_count),
    .underflow (underflow)
  );

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  logic [WD-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          en;
    logic [WD-1:0] data;
    logic          exp_flag;   // full or empty
    logic          exp_aflag;  // afull or aempty
    logic [AW:0]   exp_count;
    logic          exp_err;    // overflow or underflow
    logic          exp_rvalid;
    logic [WD-1:0] exp_rdata;
  } vec_t;

  vec_t wr_vec[18];
  vec_t rd_vec[18];

  function automatic vec_t mk(input logic en, input logic [WD-1:0] data, input logic fl,
                              input logic af, input int cnt, input logic err,
                              input logic rv, input logic [WD-1:0] rd);
    vec_t v;
    v.en = en; v.data = data; v.exp_flag = fl; v.exp_aflag = af;
    v.exp_count = (AW+1)'(cnt); v.exp_err = err; v.exp_rvalid = rv; v.exp_rdata = rd;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wr_word(input logic [WD-1:0] d);
    we = 1'b1; wdata = d;
    @(posedge clk_we); #1;
    we = 1'b0;
  endtask

  task automatic rd_word();
    re = 1'b1;
    @(posedge clk_re); #1;
    re = 1'b0;
  endtask

  task automatic wait_wr_count(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (wr_count !== (AW+1)'(target) && n < budget) begin
      @(posedge clk_we); #1; n++;
    end
    chk(name, wr_count, (AW+1)'(target));
  endtask

  task automatic producer(input int n);
    int   sent, cyc;
    logic acc;
    sent = 0; cyc = 0;
    @(posedge clk_we); #1;
    while (sent < n && cyc < 20000) begin
      if ($urandom_range(0, 3) != 0) begin
        we = 1'b1; wdata = $urandom;
      end else begin
        we = 1'b0;
      end
      acc = we && !full;
      @(posedge clk_we);
      if (acc) begin
        exp_q.push_back(wdata);
        sent++;
      end
      #1;
      chk("stream_overflow", overflow, we && !acc);
      we = 1'b0; cyc++;
    end
    chk("stream_words_sent", sent, n);
  endtask

  task automatic consumer(input int n);
    int            got, cyc;
    logic          acc;
    logic [WD-1:0] exp;
    got = 0; cyc = 0;
    @(posedge clk_re); #1;
    while (got < n && cyc < 40000) begin
      re  = ($urandom_range(0, 3) != 0);
      acc = re && !empty;
      @(posedge clk_re); #1;
      chk("stream_underflow", underflow, re && !acc);
      re = 1'b0;
      chk("stream_rvalid", rvalid, acc);
      if (acc) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_read_unwritten got %h expected queue entry", rdata);
        end else begin
          exp = exp_q.pop_front();
          chk("stream_rdata", rdata, exp);
        end
        got++;
      end
      cyc++;
    end
    chk("stream_words_read", got, n);
  endtask

  task automatic stream_phase(input int n);
    fork
      producer(n);
      consumer(n);
    join
    chk("stream_queue_drained", exp_q.size(), 0);
    repeat (8) @(posedge clk_re);
    repeat (8) @(posedge clk_we);
    #1;
    chk("stream_end_empty", empty, 1'b1);
    chk("stream_end_rd_count", rd_count, '0);
    chk("stream_end_wr_count", wr_count, '0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;

    for (int i = 0; i < 16; i++)
      wr_vec[i] = mk(1'b1, WD'(i), i == 15, (i + 1) >= 14, i + 1, 1'b0, 1'b0, '0);
    wr_vec[16] = mk(1'b1, 32'd16, 1'b1, 1'b1, 16, 1'b1, 1'b0, '0);
    wr_vec[17] = mk(1'b0, 32'd0,  1'b1, 1'b1, 16, 1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++)
      rd_vec[i] = mk(1'b1, '0, i == 15, (15 - i) <= 2, 15 - i, 1'b0, 1'b1, WD'(i));
    rd_vec[16] = mk(1'b1, '0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 32'd15);
    rd_vec[17] = mk(1'b0, '0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 32'd15);

    // 1: reset state and underflow on an empty read
    #2 rst = 1'b0;
    repeat (3) @(posedge clk_re);
    #1;
    chk("rst_empty", empty, 1'b1);
    chk("rst_aempty", aempty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_afull", afull, 1'b0);
    chk("rst_wr_count", wr_count, '0);
    chk("rst_rd_count", rd_count, '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_rvalid", rvalid, 1'b0);
    rst = 1'b1;
    @(posedge clk_re); #1;
    rd_word();
    chk("t1_underflow_pulse", underflow, 1'b1);
    chk("t1_rvalid_low", rvalid, 1'b0);
    @(posedge clk_re); #1;
    chk("t1_underflow_clear", underflow, 1'b0);

    // 2: single word latency and readback
    @(posedge clk_we); #1;
    wr_word(32'hA5A5_0001);
    chk("t2_wr_count", wr_count, 5'd1);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk_re); #1;
      n = i;
      if (!empty) break;
    end
    chk("t2_empty_latency", n, 3);
    chk("t2_rd_count", rd_count, 5'd1);
    rd_word();
    chk("t2_rvalid", rvalid, 1'b1);
    chk("t2_rdata", rdata, 32'hA5A5_0001);
    chk("t2_empty_again", empty, 1'b1);
    @(posedge clk_re); #1;
    chk("t2_rvalid_drop", rvalid, 1'b0);
    chk("t2_rdata_hold", rdata, 32'hA5A5_0001);
    wait_wr_count(0, 10, "t2_space_freed");

    // 3: fill to full and overflow
    @(posedge clk_we); #1;
    for (int i = 0; i < 18; i++) begin
      we = wr_vec[i].en; wdata = wr_vec[i].data;
      @(posedge clk_we); #1;
      we = 1'b0;
      chk($sformatf("fill%0d_full", i), full, wr_vec[i].exp_flag);
      chk($sformatf("fill%0d_afull", i), afull, wr_vec[i].exp_aflag);
      chk($sformatf("fill%0d_wr_count", i), wr_count, wr_vec[i].exp_count);
      chk($sformatf("fill%0d_overflow", i), overflow, wr_vec[i].exp_err);
    end

    // 4: drain in order
    repeat (6) @(posedge clk_re);
    #1;
    chk("drain_start_rd_count", rd_count, 5'd16);
    chk("drain_start_empty", empty, 1'b0);
    for (int i = 0; i < 18; i++) begin
      re = rd_vec[i].en;
      @(posedge clk_re); #1;
      re = 1'b0;
      chk($sformatf("drain%0d_empty", i), empty, rd_vec[i].exp_flag);
      chk($sformatf("drain%0d_aempty", i), aempty, rd_vec[i].exp_aflag);
      chk($sformatf("drain%0d_rd_count", i), rd_count, rd_vec[i].exp_count);
      chk($sformatf("drain%0d_underflow", i), underflow, rd_vec[i].exp_err);
      chk($sformatf("drain%0d_rvalid", i), rvalid, rd_vec[i].exp_rvalid);
      chk($sformatf("drain%0d_rdata", i), rdata, rd_vec[i].exp_rdata);
    end
    wait_wr_count(0, 10, "drain_space_freed");
    chk("drain_full_clear", full, 1'b0);

    // 6: reset with 9 entries held
    @(posedge clk_we); #1;
    for (int i = 0; i < 9; i++) wr_word(32'h0900_0000 + i);
    repeat (6) @(posedge clk_re);
    #1;
    chk("t6_held_rd_count", rd_count, 5'd9);
    @(posedge clk_we); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk_we);
    #1;
    chk("t6_rst_empty", empty, 1'b1);
    chk("t6_rst_full", full, 1'b0);
    chk("t6_rst_wr_count", wr_count, '0);
    chk("t6_rst_rd_count", rd_count, '0);
    chk("t6_rst_rdata", rdata, '0);
    rst = 1'b1;
    @(posedge clk_we); #1;
    wr_word(32'h600D_BEEF);
    n = 0;
    while (empty && n < 10) begin
      @(posedge clk_re); #1; n++;
    end
    chk("t6_new_not_empty", empty, 1'b0);
    chk("t6_new_rd_count", rd_count, 5'd1);
    rd_word();
    chk("t6_new_rvalid", rvalid, 1'b1);
    chk("t6_new_rdata", rdata, 32'h600D_BEEF);
    chk("t6_new_empty", empty, 1'b1);
    wait_wr_count(0, 10, "t6_space_freed");

    // 5: streaming with random stalls, fast writer then fast reader
    stream_phase(200);
    we_half = 17.0;
    re_half = 4.0;
    repeat (4) @(posedge clk_we);
    stream_phase(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- Complete dual-clock FIFO with its own write and read pointer logic.
- Pointers cross clock domains as Gray code, producing full, empty, almost-full and almost-empty flags plus occupancy counts in each domain.
- Sits between a producer on clk_we and a consumer on clk_re; callers no longer supply pointers.
- Adds overflow and underflow protection with error pulses.

Parameters:
WD, 32, data width in bits
AW, 4, address width; depth = 2**AW entries; AW >= 2
SYNC_STAGES, 2, synchroniser flops per CDC crossing; 2..4
AFULL_TH, 2**AW-2, afull asserts when wr_count >= AFULL_TH
AEMPTY_TH, 2, aempty asserts when rd_count <= AEMPTY_TH

Ports:
rst  in  1  asynchronous active-low reset, both domains
clk_we  in  1  write clock
clk_re  in  1  read clock
we  in  1  write request (clk_we)
wdata  in  WD  write data
full  out  1  FIFO full (clk_we)
afull  out  1  almost full (clk_we)
wr_count  out  AW+1  occupancy seen by write side
overflow  out  1  one-cycle pulse: we while full
re  in  1  read request (clk_re)
rdata  out  WD  registered read data
rvalid  out  1  rdata updated this cycle
empty  out  1  FIFO empty (clk_re)
aempty  out  1  almost empty (clk_re)
rd_count  out  AW+1  occupancy seen by read side
underflow  out  1  one-cycle pulse: re while empty

Behaviour:
- Interface: reset rst, asynchronous, active-low; clock clk_we. The read domain runs on clk_re and uses the same rst.
- Reset values:
  - All pointers and synchroniser flops: 0.
  - full=0, afull=0, wr_count=0, overflow=0.
  - empty=1, aempty=1, rd_count=0, underflow=0, rdata=0, rvalid=0.
  - Memory array is not reset.
- Pointers: binary and Gray, AW+1 bits each, MSB is the wrap bit. Gray = bin ^ (bin>>1).
- Write accept: we && !full. Memory at wptr[AW-1:0] is written and wptr increments on that clk_we edge. we && full: no write, pointer unchanged, overflow=1 for one cycle.
- Read accept: re && !empty. On that clk_re edge, rdata <= mem[rptr[AW-1:0]], rvalid=1 next cycle, and rptr increments. Otherwise rvalid=0 and rdata holds its value.
- re && empty: no read, underflow=1 for one cycle.
- CDC:
  - Write Gray pointer is registered in clk_we, then passed through SYNC_STAGES flops on clk_re.
  - Read Gray pointer is handled symmetrically.
  - Only Gray values cross domains.
- Flags are registered, computed from next-state pointers:
  - full = (wgray_next == {~rgray_sync[AW:AW-1], rgray_sync[AW-2:0]}).
  - empty = (rgray_next == wgray_sync).
- Counts:
  - wr_count = wbin_next - gray2bin(rgray_sync), modulo 2**(AW+1).
  - rd_count = gray2bin(wgray_sync) - rbin_next.
  - Same-cycle registered alongside the flags.
- Latency:
  - First write into an empty FIFO deasserts empty SYNC_STAGES+1 clk_re edges after the write edge.
  - A read frees space on the write side SYNC_STAGES+1 clk_we edges later.
  - Flags are pessimistic, never optimistic: full/afull may stay high and empty/aempty may stay high longer than true occupancy. No data is ever lost or duplicated.
- Simultaneous write and read in the same domain-relative cycle are independent. At full, a write is rejected even if a read is occurring on the other clock.
- Wrap-around: pointer MSB toggles every 2**AW entries. Behaviour is continuous across any number of wraps.
- Reset mid-operation: all state returns to reset values immediately. Contents are discarded logically, and FIFO reads empty after rst deasserts.
- rst deassertion must be synchronised externally per domain.
- Clock ratio: any; clocks may be equal or unrelated.

Decomposition:
- Package fifo_pkg:
  - bin2gray and gray2bin functions, parametrised by width.
  - Constant DEFAULT_SYNC_STAGES = 2.
- Sub-module fifo_sync_ff:
  - Parameters W and STAGES; async active-low reset; one instance per crossing direction.
- Memory array is inferred inline (simple dual-port, registered read).

Test Plan:
1. Reset with WD=32, AW=4: empty=1, full=0, counts=0, rdata=0; pulse re -> underflow=1 one clk_re cycle, rvalid stays 0.
2. clk_we 100 MHz, clk_re 37 MHz. Write 0xA5A5_0001 once -> empty drops after 3 clk_re edges; re -> rvalid next cycle with rdata=0xA5A5_0001; empty returns to 1.
3. Write 16 words 0..15 with no reads -> full=1 after 16th write, afull from wr_count=14. 17th we -> overflow pulse, word 16 is never read.
4. Drain all 16 entries -> data 0..15 in order, aempty at rd_count<=2, empty after last read.
5. Continuous we/re over 200 words, random stalls, both clock ratios (fast-write and fast-read) -> scoreboard exact order and pointer wraps; never full&&write or empty&&read accepted.
6. Assert rst for 2 cycles with 9 entries held -> empty=1, full=0, counts=0; next write/read pair returns the new data only.
